// File: rtl/ip_recv.sv
// IPv4 receive parser. Walks the 32-bit word stream from the receive buffer,
// folds the header into a ones-complement checksum, and validates version,
// IHL, length, checksum and destination. Accepted datagrams have their payload
// forwarded one cycle later with framing. Rejected ones are consumed silently
// after a single hdr_err pulse.
//
// Handshake: v_ip is a one-cycle strobe with no backpressure, and each strobe
// carries exactly one word. payload_valid, hdr_valid and hdr_err are
// one-cycle strobes. payload_bytes, src_ip and protocol are held until the
// next accepted header.
module ip_recv #(
  parameter logic [31:0] LOCAL_IP = 32'hC0A8_0102,
  parameter int          TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_ip,
  input  logic        v_ip,
  output logic [31:0] payload_data,
  output logic        payload_valid,
  output logic        payload_last,
  output logic [15:0] payload_bytes,
  output logic [31:0] src_ip,
  output logic [7:0]  protocol,
  output logic        hdr_valid,
  output logic        hdr_err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_HDR     = 2'd0,
    S_OPT     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_DROP    = 2'd3
  } state_t;

  localparam int IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_t        state;
  logic [3:0]    idx;
  logic [3:0]    ver_q;
  logic [3:0]    ihl_q;
  logic [15:0]   tl_q;
  logic [7:0]    proto_q;
  logic [31:0]   src_q;
  logic [31:0]   dst_q;
  logic [16:0]   acc;
  logic [15:0]   rem;
  logic [IW-1:0] idle;

  // Add both halves of a word to the accumulator, then apply end-around carry twice.
  function automatic logic [15:0] fold16(input logic [16:0] a, input logic [31:0] w);
    logic [17:0] s;
    logic [16:0] t;
    s = {1'b0, a} + {2'b00, w[31:16]} + {2'b00, w[15:0]};
    t = {1'b0, s[15:0]} + {15'd0, s[17:16]};
    return t[15:0] + {15'd0, t[16]};
  endfunction

  logic [16:0] acc_in;
  logic [15:0] acc_next;
  logic [15:0] ihl4;
  logic [15:0] pb;
  logic [15:0] n_words;
  logic [15:0] drop_n;
  logic [31:0] dst_eff;
  logic        hdr_ok;
  logic        go_opt;
  logic        decide;
  logic        active;
  logic        expired;

  // Header evaluation on the word currently presented.
  always_comb begin
    acc_in   = (state == S_HDR && idx == 4'd0) ? 17'd0 : acc;
    acc_next = fold16(acc_in, data_ip);
    ihl4     = {10'd0, ihl_q, 2'b00};
    pb       = tl_q - ihl4;
    n_words  = 16'(({1'b0, pb} + 17'd3) >> 2);
    drop_n   = (ihl_q < 4'd5 || tl_q < ihl4) ? 16'd0 : n_words;
    dst_eff  = (state == S_HDR) ? data_ip : dst_q;
    hdr_ok   = (ver_q == 4'd4) && (ihl_q >= 4'd5) && (tl_q >= ihl4) &&
               (acc_next == 16'hFFFF) &&
               (dst_eff == LOCAL_IP || dst_eff == 32'hFFFF_FFFF);
    go_opt   = (ver_q == 4'd4) && (ihl_q > 4'd5);
    decide   = v_ip && ((state == S_HDR && idx == 4'd4 && !go_opt) ||
                        (state == S_OPT && idx == ihl_q - 4'd1));
    active   = (state != S_HDR) || (idx != 4'd0);
    expired  = active && !v_ip && (idle == IW'(TIMEOUT - 1));
  end

  assign state_dbg = state;

  // Parser FSM, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_HDR;
      idx           <= 4'd0;
      ver_q         <= 4'd0;
      ihl_q         <= 4'd0;
      tl_q          <= 16'd0;
      proto_q       <= 8'd0;
      src_q         <= 32'd0;
      dst_q         <= 32'd0;
      acc           <= 17'd0;
      rem           <= 16'd0;
      idle          <= '0;
      payload_data  <= 32'd0;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      payload_bytes <= 16'd0;
      src_ip        <= 32'd0;
      protocol      <= 8'd0;
      hdr_valid     <= 1'b0;
      hdr_err       <= 1'b0;
    end else begin
      hdr_valid     <= 1'b0;
      hdr_err       <= 1'b0;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      if (v_ip) begin
        idle <= '0;
        case (state)
          S_HDR: begin
            acc <= {1'b0, acc_next};
            idx <= idx + 4'd1;
            case (idx)
              4'd0: begin
                ver_q <= data_ip[31:28];
                ihl_q <= data_ip[27:24];
                tl_q  <= data_ip[15:0];
              end
              4'd2:    proto_q <= data_ip[23:16];
              4'd3:    src_q   <= data_ip;
              4'd4:    dst_q   <= data_ip;
              default: ;
            endcase
            if (idx == 4'd4 && go_opt) state <= S_OPT;
          end
          S_OPT: begin
            acc <= {1'b0, acc_next};
            idx <= idx + 4'd1;
          end
          S_PAYLOAD: begin
            payload_valid <= 1'b1;
            payload_data  <= data_ip;
            rem           <= rem - 16'd1;
            if (rem == 16'd1) begin
              payload_last <= 1'b1;
              state        <= S_HDR;
            end
          end
          S_DROP: begin
            rem <= rem - 16'd1;
            if (rem == 16'd1) state <= S_HDR;
          end
          default: state <= S_HDR;
        endcase
        // The final header word settles the datagram's fate; this overrides
        // the per-word counter updates above.
        if (decide) begin
          idx <= 4'd0;
          acc <= 17'd0;
          if (hdr_ok) begin
            hdr_valid     <= 1'b1;
            payload_bytes <= pb;
            src_ip        <= src_q;
            protocol      <= proto_q;
            rem           <= n_words;
            state         <= (n_words == 16'd0) ? S_HDR : S_PAYLOAD;
          end else begin
            hdr_err <= 1'b1;
            rem     <= drop_n;
            state   <= (drop_n == 16'd0) ? S_HDR : S_DROP;
          end
        end
      end else if (expired) begin
        // Stalled mid-datagram: abandon it; only an undecided header reports.
        if (state == S_HDR || state == S_OPT) hdr_err <= 1'b1;
        state <= S_HDR;
        idx   <= 4'd0;
        acc   <= 17'd0;
        rem   <= 16'd0;
        idle  <= '0;
      end else if (active) begin
        idle <= idle + IW'(1);
      end else begin
        idle <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ip_recv.sv
// Bench for ip_recv: directed datagrams with hand-derived expected events,
// pushed into a queue and matched by an independent output monitor.
module tb_ip_recv;

  localparam int W       = 58;
  localparam int TIMEOUT = 16;
  localparam logic [31:0] LOCAL = 32'hC0A8_0102;
  localparam logic [31:0] SRC_A = 32'hC0A8_0101;
  localparam logic [31:0] SRC_B = 32'h0A00_0001;

  logic        clk;
  logic        reset;
  logic [31:0] data_ip;
  logic        v_ip;
  logic [31:0] payload_data;
  logic        payload_valid;
  logic        payload_last;
  logic [15:0] payload_bytes;
  logic [31:0] src_ip;
  logic [7:0]  protocol;
  logic        hdr_valid;
  logic        hdr_err;
  logic [1:0]  state_dbg;

  ip_recv #(.LOCAL_IP(LOCAL), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .data_ip(data_ip), .v_ip(v_ip),
    .payload_data(payload_data), .payload_valid(payload_valid),
    .payload_last(payload_last), .payload_bytes(payload_bytes),
    .src_ip(src_ip), .protocol(protocol), .hdr_valid(hdr_valid),
    .hdr_err(hdr_err), .state_dbg(state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  logic [31:0] pkt [0:63];
  int          pkt_len = 0;

  // Expected event encodings: kind 1 header, 2 payload word, 3 error.
  task automatic exp_hdr(input logic [15:0] pb, input logic [7:0] pr, input logic [31:0] src);
    exp_q.push_back({2'd1, pb, pr, src});
  endtask

  task automatic exp_pay(input logic last, input logic [31:0] d);
    exp_q.push_back({2'd2, 23'd0, last, d});
  endtask

  task automatic exp_err();
    exp_q.push_back({2'd3, 56'd0});
  endtask

  // Standard IPv4 header checksum over n words starting at base.
  function automatic logic [15:0] ip_csum(input int base, input int n);
    int unsigned s;
    s = 0;
    for (int i = 0; i < n; i++) s += {16'd0, pkt[base+i][31:16]} + {16'd0, pkt[base+i][15:0]};
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  // Append a header (with option words when ihl > 5) to the packet buffer.
  task automatic add_hdr(input logic [3:0] ver, input logic [3:0] ihl, input logic [15:0] tl,
                         input logic [7:0] pr, input logic [31:0] src, input logic [31:0] dst,
                         input logic [15:0] csum_delta);
    int base;
    int nh;
    logic [15:0] c;
    base = pkt_len;
    nh   = (ihl > 4'd5) ? int'(ihl) : 5;
    pkt[base+0] = {ver, ihl, 8'h00, tl};
    pkt[base+1] = 32'h1234_0000;
    pkt[base+2] = {8'h40, pr, 16'h0000};
    pkt[base+3] = src;
    pkt[base+4] = dst;
    for (int i = 5; i < nh; i++) pkt[base+i] = 32'h9404_0000;
    c = ip_csum(base, nh) + csum_delta;
    pkt[base+2][15:0] = c;
    pkt_len = base + nh;
  endtask

  task automatic add_word(input logic [31:0] w);
    pkt[pkt_len] = w;
    pkt_len++;
  endtask

  // Drive the first n buffered words back to back, then go idle.
  task automatic send_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_ip = pkt[i];
      v_ip    = 1'b1;
    end
    @(negedge clk);
    v_ip    = 1'b0;
    data_ip = 32'd0;
    pkt_len = 0;
  endtask

  task automatic send_all();
    send_n(pkt_len);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait for the monitor to consume every expected event.
  task automatic wait_drain(input string name);
    int budget;
    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every output event must match the head of the queue.
  task automatic check_evt(input logic [W-1:0] act, input string name);
    logic [W-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event %h, none expected", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h, required %h", name, act, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (hdr_err)       check_evt({2'd3, 56'd0}, "hdr_err");
      if (hdr_valid)     check_evt({2'd1, payload_bytes, protocol, src_ip}, "hdr_valid");
      if (payload_valid) check_evt({2'd2, 23'd0, payload_last, payload_data}, "payload");
    end
  end

  task automatic check_outputs_zero(input string tag);
    check_val({tag, " payload_valid"}, {31'd0, payload_valid}, 32'd0);
    check_val({tag, " payload_last"},  {31'd0, payload_last},  32'd0);
    check_val({tag, " payload_data"},  payload_data,           32'd0);
    check_val({tag, " payload_bytes"}, {16'd0, payload_bytes}, 32'd0);
    check_val({tag, " src_ip"},        src_ip,                 32'd0);
    check_val({tag, " protocol"},      {24'd0, protocol},      32'd0);
    check_val({tag, " hdr_valid"},     {31'd0, hdr_valid},     32'd0);
    check_val({tag, " hdr_err"},       {31'd0, hdr_err},       32'd0);
  endtask

  // Stimulus
  initial begin
    reset   = 1'b0;
    v_ip    = 1'b0;
    data_ip = 32'd0;
    idle(3);
    check_outputs_zero("reset");
    check_val("reset state", {30'd0, state_dbg}, 32'd0);
    reset = 1'b1;
    idle(2);

    // Valid UDP datagram, 8 payload bytes.
    exp_hdr(16'd8, 8'd17, SRC_A);
    exp_pay(1'b0, 32'hDEAD_BEEF);
    exp_pay(1'b1, 32'hCAFE_F00D);
    add_hdr(4'd4, 4'd5, 16'd28, 8'd17, SRC_A, LOCAL, 16'd0);
    add_word(32'hDEAD_BEEF);
    add_word(32'hCAFE_F00D);
    send_all();
    wait_drain("good udp");

    // Corrupted checksum: one error, payload swallowed, then a good one.
    exp_err();
    exp_hdr(16'd8, 8'd17, SRC_A);
    exp_pay(1'b0, 32'h0102_0304);
    exp_pay(1'b1, 32'h0506_0708);
    add_hdr(4'd4, 4'd5, 16'd28, 8'd17, SRC_A, LOCAL, 16'd1);
    add_word(32'hAAAA_AAAA);
    add_word(32'hBBBB_BBBB);
    add_hdr(4'd4, 4'd5, 16'd28, 8'd17, SRC_A, LOCAL, 16'd0);
    add_word(32'h0102_0304);
    add_word(32'h0506_0708);
    send_all();
    wait_drain("bad checksum");

    // One option word, 6 payload bytes in two words.
    exp_hdr(16'd6, 8'd6, SRC_B);
    exp_pay(1'b0, 32'h1111_2222);
    exp_pay(1'b1, 32'h3333_4444);
    add_hdr(4'd4, 4'd6, 16'd30, 8'd6, SRC_B, LOCAL, 16'd0);
    add_word(32'h1111_2222);
    add_word(32'h3333_4444);
    send_all();
    wait_drain("options");

    // Broadcast accepted, foreign destination dropped.
    exp_hdr(16'd4, 8'd17, SRC_B);
    exp_pay(1'b1, 32'h5555_6666);
    exp_err();
    add_hdr(4'd4, 4'd5, 16'd24, 8'd17, SRC_B, 32'hFFFF_FFFF, 16'd0);
    add_word(32'h5555_6666);
    add_hdr(4'd4, 4'd5, 16'd28, 8'd17, SRC_B, 32'hC0A8_0199, 16'd0);
    add_word(32'h7777_7777);
    add_word(32'h8888_8888);
    send_all();
    wait_drain("destination");

    // Header-only datagram, next word is a fresh header.
    exp_hdr(16'd0, 8'd1, SRC_A);
    exp_hdr(16'd4, 8'd17, SRC_A);
    exp_pay(1'b1, 32'h9999_0000);
    add_hdr(4'd4, 4'd5, 16'd20, 8'd1, SRC_A, LOCAL, 16'd0);
    add_hdr(4'd4, 4'd5, 16'd24, 8'd17, SRC_A, LOCAL, 16'd0);
    add_word(32'h9999_0000);
    send_all();
    wait_drain("header only");

    // IHL below 5: five words counted, error, nothing dropped after.
    exp_err();
    exp_hdr(16'd4, 8'd17, SRC_B);
    exp_pay(1'b1, 32'hABCD_0123);
    add_hdr(4'd4, 4'd4, 16'd28, 8'd17, SRC_B, LOCAL, 16'd0);
    add_hdr(4'd4, 4'd5, 16'd24, 8'd17, SRC_B, LOCAL, 16'd0);
    add_word(32'hABCD_0123);
    send_all();
    wait_drain("short ihl");

    // Stall after w2 until the idle timeout fires.
    exp_err();
    add_hdr(4'd4, 4'd5, 16'd28, 8'd17, SRC_A, LOCAL, 16'd0);
    send_n(3);
    idle(TIMEOUT + 6);
    wait_drain("timeout");
    exp_hdr(16'd4, 8'd17, SRC_A);
    exp_pay(1'b1, 32'h2468_ACE0);
    add_hdr(4'd4, 4'd5, 16'd24, 8'd17, SRC_A, LOCAL, 16'd0);
    add_word(32'h2468_ACE0);
    send_all();
    wait_drain("after timeout");

    // Reset mid-payload, then a fresh datagram.
    exp_hdr(16'd8, 8'd17, SRC_B);
    exp_pay(1'b0, 32'h1357_9BDF);
    add_hdr(4'd4, 4'd5, 16'd28, 8'd17, SRC_B, LOCAL, 16'd0);
    add_word(32'h1357_9BDF);
    send_n(6);
    idle(2);
    wait_drain("pre reset");
    reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("mid reset");
    reset = 1'b1;
    exp_hdr(16'd8, 8'd17, SRC_A);
    exp_pay(1'b0, 32'hFEED_0001);
    exp_pay(1'b1, 32'hFEED_0002);
    add_hdr(4'd4, 4'd5, 16'd28, 8'd17, SRC_A, LOCAL, 16'd0);
    add_word(32'hFEED_0001);
    add_word(32'hFEED_0002);
    send_all();
    wait_drain("after reset");

    idle(5);
    check_val("queue empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
